sdram_bist_master: RTL
======================

Name: sdram_bist_master

Overview:
- Avalon-MM built-in-self-test master that sits upstream of the SDRAM controller inside sopc_system.
- Connects to the controller's s1 slave through the interconnect.
- Fills a configurable SDRAM region with a deterministic pattern, reads it back with pipelined reads, compares each word, and reports pass/fail, error count and first failing address.
- Used for board bring-up and lab validation of the SDRAM path.

Parameters:
- ADDR_W, 24, word-address width; 2^24 x16 words = 32 MB.
- DATA_W, 16, data width; must match the SDRAM controller.
- MAX_PEND, 4, maximum outstanding reads (1..15).

Ports:
- clk_clk  in  1  system clock, same domain as the SDRAM controller.
- reset_reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a test.
- base_addr  in  ADDR_W  first word address, latched on accepted start.
- word_count  in  ADDR_W+1  number of words to test, latched on accepted start.
- busy  out  1  test in progress.
- done  out  1  test finished; held until next accepted start.
- pass  out  1  valid when done; 1 = no mismatches.
- err_count  out  16  mismatch count, saturates at 16'hFFFF.
- first_err_addr  out  ADDR_W  word address of first mismatch.
- avm_address  out  ADDR_W+1  byte address = word address << 1.
- avm_write  out  1  write request.
- avm_writedata  out  DATA_W  write data.
- avm_byteenable  out  DATA_W/8  all ones whenever avm_write or avm_read is high, else 0.
- avm_read  out  1  read request.
- avm_readdata  in  DATA_W  read data.
- avm_readdatavalid  in  1  read data valid.
- avm_waitrequest  in  1  slave stall.

Behaviour:
- Clock and reset: one clock, clk_clk. Reset is reset_reset_n, asynchronous, active-low.
- Reset: all outputs 0, FSM in IDLE, pending = 0. Reset mid-test aborts immediately: avm_read/avm_write drop asynchronously and no partial result is retained.
- FSM states: IDLE, WRITE, READ, DRAIN, DONE.
- Start acceptance: start is accepted only in IDLE or DONE and ignored while busy. On acceptance: latch base_addr and word_count, clear err_count, first_err_addr, done and pass, set busy, reset the pattern generator.
  - word_count = 0: go directly to DONE the next cycle with pass = 1.
  - Otherwise: enter WRITE.
- WRITE:
  - avm_write = 1, avm_address = (base + wi) << 1, avm_writedata = pattern(wi).
  - While avm_waitrequest = 1, address and data are held stable.
  - A cycle with avm_write high and avm_waitrequest low accepts the word and increments wi.
  - The cycle after the last word is accepted, avm_write = 0 and the FSM enters READ.
- READ:
  - avm_read asserts when issued < count and pending < MAX_PEND.
  - An accepted read (read high, waitrequest low) increments issued.
  - Once asserted, avm_read and avm_address hold until accepted, even if a readdatavalid frees a slot.
  - When issued == count, the FSM enters DRAIN.
- pending counter:
  - +1 per accepted read, −1 per avm_readdatavalid; both in the same cycle leaves it unchanged.
  - Never exceeds MAX_PEND and never underflows. avm_readdatavalid while pending = 0 is ignored.
- Compare:
  - Responses arrive in order. Each valid beat compares avm_readdata with pattern(ri), then ri increments.
  - On mismatch: err_count increments (saturating at 16'hFFFF). On the first mismatch only, first_err_addr = base + ri.
- DRAIN: wait until pending = 0 and ri == count, then go to DONE.
- DONE:
  - busy = 0, done = 1, pass = (err_count == 0). Results hold until the next accepted start.
  - A start arriving in the same cycle DONE is entered is accepted the following cycle.
- Address wrap: base + i wraps modulo 2^ADDR_W with no error.
- Default pattern: pattern(i) = i[15:0] XOR 16'hA5A5.

Optional Feature:
- Macro: SDRAM_BIST_LFSR_EN.
- Defined: pattern(i) is the i-th output of a 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1, seed 16'hACE1 (pattern(0) = 16'hACE1). The LFSR advances once per accepted write and once per read-data beat, with separate generator instances for the write and compare sides, each reseeded at start.
- Undefined: the address-XOR pattern is used and no LFSR logic is synthesized.

Test Plan:
- Reset asserted at time 0, then released → every output is 0, FSM IDLE; start held 0 for 20 cycles → no bus activity.
- Zero-wait slave model, base = 0x100, count = 8 → exactly 8 writes then 8 reads; write 3 has address 0x206 and data 16'hA5A6; done = 1, pass = 1, err_count = 0.
- waitrequest held high for 3 cycles on write 2 → address and data stable for 4 cycles, no duplicate or skipped word, total accepted writes = 8.
- Slave corrupts readdata of word index 5 (base = 0) → err_count = 1, first_err_addr = 5, pass = 0.
- Slave read latency of 10 cycles, MAX_PEND = 4, count = 32 → outstanding reads never exceed 4; all 32 compared; pass = 1.
- Reset pulsed during READ with 3 reads pending → avm_read falls immediately and busy = 0; a new start with count = 4 completes with pass = 1 and late readdatavalid beats are ignored.

Source files
------------

// File: rtl/sdram_bist_master_if.sv
// Avalon-MM master bus between the SDRAM BIST engine and the controller's s1 slave.
// Addresses are byte addresses; the slave side returns read data in order.
interface sdram_bist_master_if #(
   parameter int ADDR_W = 24,
   parameter int DATA_W = 16
);
   logic [ADDR_W:0]     avm_address;
   logic                avm_write;
   logic [DATA_W-1:0]   avm_writedata;
   logic [DATA_W/8-1:0] avm_byteenable;
   logic                avm_read;
   logic [DATA_W-1:0]   avm_readdata;
   logic                avm_readdatavalid;
   logic                avm_waitrequest;

   modport master (
      output avm_address, avm_write, avm_writedata, avm_byteenable, avm_read,
      input  avm_readdata, avm_readdatavalid, avm_waitrequest
   );

   modport slave (
      input  avm_address, avm_write, avm_writedata, avm_byteenable, avm_read,
      output avm_readdata, avm_readdatavalid, avm_waitrequest
   );
endinterface

// File: rtl/sdram_bist_master.sv
// SDRAM BIST master: writes a pattern over a word region, reads it back pipelined and compares.
// Define SDRAM_BIST_LFSR_EN to use a 16-bit LFSR pattern instead of index XOR 16'hA5A5.
module sdram_bist_master #(
   parameter int ADDR_W   = 24,
   parameter int DATA_W   = 16,
   parameter int MAX_PEND = 4
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   word_count,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [15:0]       err_count,
   output logic [ADDR_W-1:0] first_err_addr,
   sdram_bist_master_if.master avm
);

   localparam int               PW         = $clog2(MAX_PEND + 1);
   localparam logic [PW-1:0]    PEND_LIMIT = PW'(MAX_PEND);
   localparam logic [ADDR_W:0]  C_ONE      = (ADDR_W+1)'(1);

   typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_base;
   logic [ADDR_W:0]     r_count;
   logic [ADDR_W:0]     r_wi;
   logic [ADDR_W:0]     r_issued;
   logic [ADDR_W:0]     r_ri;
   logic [PW-1:0]       r_pend;
   logic [15:0]         r_err;
   logic [ADDR_W-1:0]   r_first;
   logic                r_busy;
   logic                r_done;
   logic                r_pass;
   logic                r_write;
   logic                r_read;
   logic [ADDR_W:0]     r_addr;
   logic [DATA_W-1:0]   r_wdata;

   logic                w_wr_acc;
   logic                w_rd_acc;
   logic                w_beat;
   logic                w_mism;
   logic [PW-1:0]       w_pend_nx;
   logic [ADDR_W:0]     w_issued_nx;
   logic [ADDR_W:0]     w_wi_nx;
   logic [DATA_W-1:0]   w_rpat;
   logic [DATA_W-1:0]   w_wpat_nx;
   logic [DATA_W-1:0]   w_pat0;

   function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] b,
                                                    input logic [ADDR_W:0]   i);
      return b + i[ADDR_W-1:0];
   endfunction

   function automatic logic [ADDR_W:0] byte_addr(input logic [ADDR_W-1:0] b,
                                                  input logic [ADDR_W:0]   i);
      return {word_addr(b, i), 1'b0};
   endfunction

`ifdef SDRAM_BIST_LFSR_EN
   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   logic [15:0] r_wlfsr;
   logic [15:0] r_rlfsr;

   // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting right
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
   endfunction

   assign w_rpat    = DATA_W'(r_rlfsr);
   assign w_wpat_nx = DATA_W'(lfsr_next(r_wlfsr));
   assign w_pat0    = DATA_W'(LFSR_SEED);
`else
   function automatic logic [DATA_W-1:0] pat_xor(input logic [ADDR_W:0] i);
      logic [15:0] v;
      v = i[15:0] ^ 16'hA5A5;
      return DATA_W'(v);
   endfunction

   assign w_rpat    = pat_xor(r_ri);
   assign w_wpat_nx = pat_xor(w_wi_nx);
   assign w_pat0    = pat_xor('0);
`endif

   assign w_wr_acc    = r_write & ~avm.avm_waitrequest;
   assign w_rd_acc    = r_read & ~avm.avm_waitrequest;
   // A beat with nothing outstanding is stale (e.g. after an aborting reset)
   assign w_beat      = avm.avm_readdatavalid & (r_pend != '0);
   assign w_mism      = w_beat & (avm.avm_readdata != w_rpat);
   assign w_pend_nx   = r_pend + PW'(w_rd_acc) - PW'(w_beat);
   assign w_issued_nx = r_issued + (w_rd_acc ? C_ONE : '0);
   assign w_wi_nx     = r_wi + C_ONE;

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_state  <= S_IDLE;
         r_base   <= '0;
         r_count  <= '0;
         r_wi     <= '0;
         r_issued <= '0;
         r_ri     <= '0;
         r_pend   <= '0;
         r_err    <= '0;
         r_first  <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_pass   <= 1'b0;
         r_write  <= 1'b0;
         r_read   <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
`ifdef SDRAM_BIST_LFSR_EN
         r_wlfsr  <= '0;
         r_rlfsr  <= '0;
`endif
      end else begin
         r_pend <= w_pend_nx;

         if (w_beat) begin
            r_ri <= r_ri + C_ONE;
`ifdef SDRAM_BIST_LFSR_EN
            r_rlfsr <= lfsr_next(r_rlfsr);
`endif
            if (w_mism) begin
               if (r_err != 16'hFFFF) r_err <= r_err + 16'd1;
               if (r_err == 16'd0)    r_first <= word_addr(r_base, r_ri);
            end
         end

         unique case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_base   <= base_addr;
                  r_count  <= word_count;
                  r_err    <= '0;
                  r_first  <= '0;
                  r_wi     <= '0;
                  r_issued <= '0;
                  r_ri     <= '0;
                  r_addr   <= byte_addr(base_addr, '0);
                  r_wdata  <= w_pat0;
`ifdef SDRAM_BIST_LFSR_EN
                  r_wlfsr  <= LFSR_SEED;
                  r_rlfsr  <= LFSR_SEED;
`endif
                  if (word_count == '0) begin
                     r_state <= S_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_pass  <= 1'b1;
                  end else begin
                     r_state <= S_WRITE;
                     r_busy  <= 1'b1;
                     r_done  <= 1'b0;
                     r_pass  <= 1'b0;
                     r_write <= 1'b1;
                  end
               end
            end

            S_WRITE: begin
               if (w_wr_acc) begin
                  if (w_wi_nx == r_count) begin
                     r_write <= 1'b0;
                     r_state <= S_READ;
                  end else begin
                     r_wi    <= w_wi_nx;
                     r_addr  <= byte_addr(r_base, w_wi_nx);
                     r_wdata <= w_wpat_nx;
`ifdef SDRAM_BIST_LFSR_EN
                     r_wlfsr <= lfsr_next(r_wlfsr);
`endif
                  end
               end
            end

            S_READ: begin
               r_issued <= w_issued_nx;
               // A stalled request stays put even if a returning beat frees a slot
               if (!r_read || w_rd_acc) begin
                  if (w_issued_nx == r_count) begin
                     r_read  <= 1'b0;
                     r_state <= S_DRAIN;
                  end else begin
                     r_read <= (w_pend_nx < PEND_LIMIT);
                     r_addr <= byte_addr(r_base, w_issued_nx);
                  end
               end
            end

            S_DRAIN: begin
               if (r_pend == '0 && r_ri == r_count) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_pass  <= (r_err == 16'd0);
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy               = r_busy;
   assign done               = r_done;
   assign pass               = r_pass;
   assign err_count          = r_err;
   assign first_err_addr     = r_first;
   assign avm.avm_address    = r_addr;
   assign avm.avm_write      = r_write;
   assign avm.avm_writedata  = r_wdata;
   assign avm.avm_read       = r_read;
   assign avm.avm_byteenable = {(DATA_W/8){r_write | r_read}};

endmodule
